// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
// Shared definitions for the MM:SS stopwatch core.
//   sw_state_e    : control FSM states (IDLE, RUN, PAUSE)
//   *_MAX         : terminal value of each BCD digit before it rolls to 0
// -----------------------------------------------------------------------------
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } sw_state_e;

    localparam logic [3:0] SEC_ONES_MAX = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;
    localparam logic [3:0] MIN_ONES_MAX = 4'd9;
    localparam logic [3:0] MIN_TENS_MAX = 4'd5;

endpackage : stopwatch_pkg

// File: rtl/bcd_digit_counter.sv
// -----------------------------------------------------------------------------
// bcd_digit_counter
// One BCD digit implemented as a modulo-(MAX+1) counter.
//   MAX   : last legal value; the digit returns to 0 after it
//   clk   : in  1  rising-edge clock
//   rst   : in  1  asynchronous active-high reset (digit -> 0)
//   clr   : in  1  synchronous clear, wins over inc
//   inc   : in  1  advance the digit by one on this edge
//   digit : out 4  registered digit value, 0..MAX
//   carry : out 1  combinational: inc while digit == MAX (feeds the next digit)
// -----------------------------------------------------------------------------
module bcd_digit_counter #(
    parameter logic [3:0] MAX = 4'd9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] digit,
    output logic       carry
);

    logic [3:0] digit_q;
    logic [3:0] digit_d;

    // NOTE: every combinational output takes a default before any branch so
    // that no path leaves it unassigned, which would infer a latch.
    always_comb begin
        digit_d = digit_q;
        if (clr) begin
            digit_d = 4'd0;
        end else if (inc) begin
            digit_d = (digit_q == MAX) ? 4'd0 : digit_q + 4'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; reset is in the sensitivity list, making it asynchronous.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_q <= 4'd0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit = digit_q;
    assign carry = inc & (digit_q == MAX);

endmodule : bcd_digit_counter

// File: rtl/bcd_stopwatch_counter.sv
// -----------------------------------------------------------------------------
// bcd_stopwatch_counter
// Up-counting MM:SS stopwatch: a prescaler produces one tick every TICK_DIV
// clocks while running, and the tick advances a chain of four BCD digits.
//   TICK_DIV   : clocks per count step (>= 2)
//   PRE_W      : prescaler width, 2**PRE_W >= TICK_DIV
//   clk        : in  1  system clock
//   rst        : in  1  asynchronous active-high reset
//   start_stop : in  1  pulse, IDLE/PAUSE -> RUN, RUN -> PAUSE
//   clear      : in  1  pulse, zero digits and prescaler, go to IDLE (wins)
//   bcd3..bcd0 : out 4  minutes tens/ones, seconds tens/ones (registered)
//   running    : out 1  high while in RUN (registered)
//   wrap       : out 1  one-cycle pulse alongside the 59:59 -> 00:00 rollover
// -----------------------------------------------------------------------------
module bcd_stopwatch_counter #(
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter int unsigned PRE_W    = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_stop,
    input  logic       clear,
    output logic [3:0] bcd3,
    output logic [3:0] bcd2,
    output logic [3:0] bcd1,
    output logic [3:0] bcd0,
    output logic       running,
    output logic       wrap
);

    import stopwatch_pkg::*;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);

    sw_state_e        state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic             running_q;
    logic             wrap_q;

    logic             tick;
    logic             carry0, carry1, carry2, carry3;

    // The prescaler only advances in RUN, so a tick can only occur there.
    assign tick = (state_q == RUN) && (pre_q == PRE_LAST);

    // ---------------- FSM + prescaler next-state ----------------
    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        if (clear) begin
            state_d = IDLE;
            pre_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_stop) begin
                        state_d = RUN;
                        pre_d   = '0;
                    end
                end
                RUN: begin
                    // The prescaler still steps on the pausing edge, so a tick
                    // that coincides with start_stop is not lost.
                    pre_d = tick ? '0 : pre_q + PRE_ONE;
                    if (start_stop) begin
                        state_d = PAUSE;
                    end
                end
                PAUSE: begin
                    // Resume keeps the held prescaler value.
                    if (start_stop) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = IDLE;
                    pre_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pre_q     <= '0;
            running_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            // Registered from the next state so running changes on the very
            // edge that samples start_stop or clear.
            running_q <= (state_d == RUN);
            // clear suppresses the rollover even though the digit chain would
            // otherwise carry out of 59:59 on this edge.
            wrap_q    <= carry3 & ~clear;
        end
    end

    // ---------------- digit chain ----------------
    bcd_digit_counter #(.MAX(SEC_ONES_MAX)) u_sec_ones (
        .clk   (clk),
        .rst   (rst),
        .clr   (clear),
        .inc   (tick),
        .digit (bcd0),
        .carry (carry0)
    );

    bcd_digit_counter #(.MAX(SEC_TENS_MAX)) u_sec_tens (
        .clk   (clk),
        .rst   (rst),
        .clr   (clear),
        .inc   (carry0),
        .digit (bcd1),
        .carry (carry1)
    );

    bcd_digit_counter #(.MAX(MIN_ONES_MAX)) u_min_ones (
        .clk   (clk),
        .rst   (rst),
        .clr   (clear),
        .inc   (carry1),
        .digit (bcd2),
        .carry (carry2)
    );

    bcd_digit_counter #(.MAX(MIN_TENS_MAX)) u_min_tens (
        .clk   (clk),
        .rst   (rst),
        .clr   (clear),
        .inc   (carry2),
        .digit (bcd3),
        .carry (carry3)
    );

    assign running = running_q;
    assign wrap    = wrap_q;

endmodule : bcd_stopwatch_counter

// File: tb/tb_bcd_stopwatch_counter.sv
// -----------------------------------------------------------------------------
// tb_bcd_stopwatch_counter
// Directed + randomized stimulus for bcd_stopwatch_counter with TICK_DIV = 4.
// The reference model keeps elapsed time as a plain seconds count (0..3599)
// plus a cycle phase; expected digits are derived from it arithmetically.
// -----------------------------------------------------------------------------
module tb_bcd_stopwatch_counter;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_stop;
    logic       clear;
    logic [3:0] bcd3, bcd2, bcd1, bcd0;
    logic       running;
    logic       wrap;

    int tests = 0;
    int fails = 0;

    // Reference model
    int m_sec;     // elapsed seconds, 0..3599
    int m_phase;   // clocks counted toward the next second while running
    bit m_run;     // currently counting
    bit m_active;  // started since the last clear/reset
    bit m_wrap;    // rollover happened on the last edge

    bcd_stopwatch_counter #(.TICK_DIV(TD), .PRE_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_stop (start_stop),
        .clear      (clear),
        .bcd3       (bcd3),
        .bcd2       (bcd2),
        .bcd1       (bcd1),
        .bcd0       (bcd0),
        .running    (running),
        .wrap       (wrap)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach its end, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_sec    = 0;
        m_phase  = 0;
        m_run    = 1'b0;
        m_active = 1'b0;
        m_wrap   = 1'b0;
    endtask

    task automatic model_edge(input bit ss, input bit clr);
        if (clr) begin
            model_reset();
        end else begin
            m_wrap = 1'b0;
            if (m_run) begin
                m_phase++;
                if (m_phase == TD) begin
                    m_phase = 0;
                    m_sec   = (m_sec + 1) % 3600;
                    m_wrap  = (m_sec == 0);
                end
            end
            if (ss) begin
                if (!m_active) begin
                    m_active = 1'b1;
                    m_run    = 1'b1;
                    m_phase  = 0;
                end else begin
                    m_run = !m_run;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".bcd3"},    bcd3,    m_sec / 600);
        check({tag, ".bcd2"},    bcd2,    (m_sec / 60) % 10);
        check({tag, ".bcd1"},    bcd1,    (m_sec % 60) / 10);
        check({tag, ".bcd0"},    bcd0,    m_sec % 10);
        check({tag, ".running"}, running, int'(m_run));
        check({tag, ".wrap"},    wrap,    int'(m_wrap));
    endtask

    // One clock edge: drive at negedge, advance model at posedge, sample 1 after.
    task automatic step(input bit ss, input bit clr, input string tag);
        @(negedge clk);
        start_stop = ss;
        clear      = clr;
        @(posedge clk);
        model_edge(ss, clr);
        #1;
        check_all(tag);
    endtask

    initial begin
        rst        = 1'b1;
        start_stop = 1'b0;
        clear      = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // Idle 20 cycles with an asynchronous reset pulse in the middle.
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, "idle");
            if (i == 10) begin
                #2;
                rst = 1'b1;
                #1;
                model_reset();
                check_all("idle_rst");
                #1;
                rst = 1'b0;
            end
        end

        // Start and run 40 cycles: first step exactly TD edges after start.
        step(1'b1, 1'b0, "start");
        for (int k = 1; k <= 40; k++) begin
            step(1'b0, 1'b0, "run40");
            if (k == TD - 1) check("first_step_early", bcd0, 0);
            if (k == TD)     check("first_step_on",    bcd0, 1);
        end
        check("run40.bcd1",    bcd1,    1);
        check("run40.bcd0",    bcd0,    0);
        check("run40.running", running, 1);

        // Run on to 01:00.
        for (int k = 0; k < 400 && !(m_sec == 60 && m_phase == 0); k++)
            step(1'b0, 1'b0, "to_0100");
        check("0100.bcd2", bcd2, 1);
        check("0100.bcd1", bcd1, 0);
        check("0100.bcd0", bcd0, 0);

        // Run on to the last cycle of 59:59, then roll over.
        for (int k = 0; k < 20000 && !(m_sec == 3599 && m_phase == TD - 1); k++)
            step(1'b0, 1'b0, "to_5959");
        check("5959.bcd3", bcd3, 5);
        check("5959.bcd2", bcd2, 9);
        check("5959.bcd1", bcd1, 5);
        check("5959.bcd0", bcd0, 9);
        step(1'b0, 1'b0, "rollover");
        check("rollover.wrap",    wrap,    1);
        check("rollover.digits",  {bcd3, bcd2, bcd1, bcd0}, 0);
        check("rollover.running", running, 1);
        step(1'b0, 1'b0, "after_wrap");
        check("after_wrap.wrap", wrap, 0);

        // Pause with prescaler at 2, resume: next step 2 edges later.
        step(1'b0, 1'b1, "clr_before_pause");
        step(1'b1, 1'b0, "p_start");
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0, "p_run");
        step(1'b1, 1'b0, "pause");
        check("pause.bcd0",    bcd0,    1);
        check("pause.running", running, 0);
        for (int k = 0; k < 10; k++) step(1'b0, 1'b0, "paused");
        check("paused.bcd0", bcd0, 1);
        step(1'b1, 1'b0, "resume");
        check("resume.running", running, 1);
        step(1'b0, 1'b0, "resume1");
        check("resume1.bcd0", bcd0, 1);
        step(1'b0, 1'b0, "resume2");
        check("resume2.bcd0", bcd0, 2);

        // clear + start_stop together at 00:07: clear wins.
        for (int k = 0; k < 100 && m_sec != 7; k++) step(1'b0, 1'b0, "to_0007");
        check("0007.bcd0", bcd0, 7);
        step(1'b1, 1'b1, "clr_ss");
        check("clr_ss.digits",  {bcd3, bcd2, bcd1, bcd0}, 0);
        check("clr_ss.running", running, 0);
        step(1'b0, 1'b0, "clr_ss_idle");
        check("clr_ss_idle.running", running, 0);

        // Asynchronous reset at 12:34, between edges.
        step(1'b1, 1'b0, "s_start");
        for (int k = 0; k < 4000 && m_sec != 754; k++) step(1'b0, 1'b0, "to_1234");
        check("1234.digits", {bcd3, bcd2, bcd1, bcd0}, 16'h1234);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("async_rst.digits",  {bcd3, bcd2, bcd1, bcd0}, 0);
        check("async_rst.running", running, 0);
        check("async_rst.wrap",    wrap,    0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) step(1'b0, 1'b0, "post_rst_idle");
        check("post_rst_idle.bcd0", bcd0, 0);
        step(1'b1, 1'b0, "post_rst_start");
        check("post_rst_start.running", running, 1);

        // Randomized control pulses against the model.
        for (int k = 0; k < 600; k++)
            step($urandom_range(7) == 0, $urandom_range(31) == 0, "rand");

        @(negedge clk);
        start_stop = 1'b0;
        clear      = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_bcd_stopwatch_counter
